// File: rtl/serial_sub_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The issuing controller (or bench) is the master; the subtractor is the slave.
interface serial_sub_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Zero;
    logic             Neg;
    logic             Ovf;

    modport master (
        output Start, A, B, Bin,
        input  Busy, Done, Diff, Bout, Zero, Neg, Ovf
    );

    modport slave (
        input  Start, A, B, Bin,
        output Busy, Done, Diff, Bout, Zero, Neg, Ovf
    );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial A - B - Bin, one bit per clock LSB first, with a single borrow flop.
// Result flags are registered only at the completion edge and held across later runs.
module serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic       CLK,
    input  logic       RST,
    serial_sub_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] sa_q,     sa_d;
    logic [WIDTH-1:0] sb_q,     sb_d;
    logic [WIDTH-1:0] sd_q,     sd_d;
    logic             borrow_q, borrow_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;
    logic             zero_q,   zero_d;
    logic             neg_q,    neg_d;
    logic             ovf_q,    ovf_d;

    logic             bit_a, bit_b, bit_d, borrow_next;
    logic [WIDTH-1:0] sd_next;
    logic             last_bit;

    assign bit_a       = sa_q[0];
    assign bit_b       = sb_q[0];
    assign bit_d       = bit_a ^ bit_b ^ borrow_q;
    assign borrow_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);
    assign sd_next     = {bit_d, sd_q[WIDTH-1:1]};
    assign last_bit    = (count_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        borrow_d = borrow_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    sa_d     = bus.A;
                    sb_d     = bus.B;
                    borrow_d = bus.Bin;
                    a_msb_d  = bus.A[WIDTH-1];
                    b_msb_d  = bus.B[WIDTH-1];
                    count_d  = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                sa_d     = {1'b0, sa_q[WIDTH-1:1]};
                sb_d     = {1'b0, sb_q[WIDTH-1:1]};
                sd_d     = sd_next;
                borrow_d = borrow_next;
                count_d  = count_q + 1'b1;
                if (last_bit) begin
                    // Flags come from the fully assembled result, including this bit.
                    state_d = S_DONE;
                    diff_d  = sd_next;
                    bout_d  = borrow_next;
                    zero_d  = (sd_next == '0);
                    neg_d   = bit_d;
                    ovf_d   = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            borrow_q <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            borrow_q <= borrow_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.Busy = (state_q == S_RUN);
    assign bus.Done = (state_q == S_DONE);
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
    assign bus.Zero = zero_q;
    assign bus.Neg  = neg_q;
    assign bus.Ovf  = ovf_q;
endmodule
